pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter generator for the pipelined MIPS core; the successor of the single-cycle next-PC block.
- Adds a fetch hold from instruction memory, redirects resolved in ID and computed from the branching instruction's own PC, a one-deep pending-redirect buffer, exception-vector entry, ERET return, and address-error flagging.
- Sits in IF; drives the instruction-memory address and the IF/ID PC.

Parameters:
- XLEN, 32, address width; must be >= 32.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on an exception request.
- STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fetch_hold  in  1  instruction memory not ready; PC must not advance.
- redir_valid  in  1  one-cycle pulse from ID: control-transfer instruction resolved taken.
- redir_op  in  2  transfer type: 2'b01 BR, 2'b10 J, 2'b11 JR; 2'b00 reserved, ignored.
- redir_base_pc  in  XLEN  PC of the branch/jump instruction.
- b_imm  in  16  branch word offset.
- j_imm  in  26  jump index.
- rs  in  XLEN  register target for JR.
- exc_req  in  1  exception entry pulse from the CP0 stage.
- eret_req  in  1  exception return pulse.
- epc  in  XLEN  return address used with eret_req.
- pc  out  XLEN  current fetch address.
- pending  out  1  a redirect is buffered awaiting hold release.
- fetch_adel  out  1  high when pc[1:0] != 0.

Behaviour:
- Reset: takes priority over every other input.
  - pc <= RESET_PC; pending <= 0; pending target <= 0; state <= RUN.
  - fetch_adel is 0 after reset, since RESET_PC is aligned.
- Target computation (combinational):
  - seq = pc + STEP.
  - link = redir_base_pc + 4.
  - BR: link + (sign-extend b_imm to XLEN, shifted left by 2).
  - J: {link[XLEN-1:28], j_imm, 2'b00}.
  - JR: rs, used unaltered. No realignment; a misaligned target surfaces on fetch_adel.
  - All additions are modulo 2^XLEN; wrap-around is silent.
- States:
  - RUN: no buffered redirect.
  - PEND: redirect target held in a pending register.
- Per-cycle priority, highest first. Each rule is a registered update visible on the next cycle.
  1. exc_req: pc <= EXC_VECTOR; clear pending; go to RUN. Ignores fetch_hold. eret_req and redir_valid in the same cycle are discarded.
  2. eret_req: pc <= epc; clear pending; go to RUN. Ignores fetch_hold.
  3. PEND with fetch_hold=0: pc <= pending target; go to RUN. A simultaneous redir_valid is discarded, because it comes from a wrong-path instruction.
  4. PEND with fetch_hold=1: pc holds. Any new redir_valid is discarded; the buffer is not overwritten.
  5. RUN with redir_valid and a legal op, fetch_hold=0: pc <= target.
  6. RUN with redir_valid and a legal op, fetch_hold=1: pc holds; latch target; go to PEND.
  7. RUN with fetch_hold=1: pc holds.
  8. Otherwise: pc <= seq.
- Reserved redir_op with redir_valid behaves as if redir_valid=0.
- Latency: redirect to new pc is 1 cycle when not held, or 1 cycle after the first cycle with fetch_hold low.
- pending output equals (state == PEND).
- Reset mid-PEND discards the buffered target.

Decomposition:
- Shared package cpu_pkg holds:
  - REDIR_NONE/BR/J/JR encodings;
  - RESET_PC and EXC_VECTOR defaults;
  - the RUN/PEND state enum.
- One natural sub-module, pc_target_calc: combinational BR/J/JR target from base_pc, immediates and rs. It is reused by the ID-stage branch predictor check.

Test Plan:
- Reset, then 3 cycles with no inputs -> pc = 0x3000, 0x3004, 0x3008, 0x300C; pending=0.
- BR: base 0x3008, b_imm 0xFFFE -> next pc 0x3004. J: base 0x3FFFFFFC, j_imm 0x0000400 -> 0x40001000 (link carries into bit 30).
- JR: redir_valid with rs=0x3102 and fetch_hold=1 for 3 cycles -> pc holds and pending=1 throughout. A second redirect (J) during the hold is discarded. On hold release, pc=0x3102 next cycle and fetch_adel=1.
- exc_req with fetch_hold=1 and pending=1 -> next pc=0x4180, pending=0. eret_req with epc=0x3020 -> next pc=0x3020.
- exc_req, eret_req and redir_valid asserted together -> pc=0x4180.
- reset asserted while in PEND -> pc=0x3000, pending=0, and the buffered target is never applied.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: redirect encodings, fetch reset/exception addresses
// and the fetch-unit state enum.
package cpu_pkg;

  localparam int unsigned REDIR_OP_W = 2;

  typedef enum logic [REDIR_OP_W-1:0] {
    REDIR_NONE = 2'b00,
    REDIR_BR   = 2'b01,
    REDIR_J    = 2'b10,
    REDIR_JR   = 2'b11
  } redir_op_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam int unsigned STEP_DEF       = 4;

  // RUN: nothing buffered; PEND: a redirect target waits for fetch_hold to drop.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational BR/J/JR target from the transfer instruction's own PC.
// Also used by the ID-stage branch predictor check.
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [REDIR_OP_W-1:0] op,
  input  logic [XLEN-1:0]       base_pc,
  input  logic [15:0]           b_imm,
  input  logic [25:0]           j_imm,
  input  logic [XLEN-1:0]       rs,
  output logic [XLEN-1:0]       target_c,
  output logic                  legal_c
);

  logic [XLEN-1:0] link;
  logic [XLEN-1:0] br_off;

  assign link   = base_pc + XLEN'(4);
  assign br_off = {{(XLEN-18){b_imm[15]}}, b_imm, 2'b00};

  // JR target is passed through untouched; misalignment is flagged downstream.
  always_comb begin
    target_c = '0;
    legal_c  = 1'b1;
    case (op)
      REDIR_BR: target_c = link + br_off;
      REDIR_J:  target_c = {link[XLEN-1:28], j_imm, 2'b00};
      REDIR_JR: target_c = rs;
      default:  legal_c  = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage program counter: sequential fetch, held redirects, exception entry,
// ERET return and misaligned-fetch flagging.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(EXC_VECTOR_DEF),
  parameter int unsigned     STEP       = STEP_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_hold,
  input  logic                  redir_valid,
  input  logic [REDIR_OP_W-1:0] redir_op,
  input  logic [XLEN-1:0]       redir_base_pc,
  input  logic [15:0]           b_imm,
  input  logic [25:0]           j_imm,
  input  logic [XLEN-1:0]       rs,
  input  logic                  exc_req,
  input  logic                  eret_req,
  input  logic [XLEN-1:0]       epc,
  output logic [XLEN-1:0]       pc,
  output logic                  pending,
  output logic                  fetch_adel
);

  fetch_state_e    state;
  logic [XLEN-1:0] pend_tgt;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] redir_tgt;
  logic            redir_legal;

  assign seq_pc  = pc + XLEN'(STEP);
  assign pending = (state == ST_PEND);

  pc_target_calc #(.XLEN(XLEN)) u_target (
    .op       (redir_op),
    .base_pc  (redir_base_pc),
    .b_imm    (b_imm),
    .j_imm    (j_imm),
    .rs       (rs),
    .target_c (redir_tgt),
    .legal_c  (redir_legal)
  );

  // fetch_adel is registered alongside every pc load so it always tracks pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      fetch_adel <= |RESET_PC[1:0];
      pend_tgt   <= '0;
      state      <= ST_RUN;
    end else if (exc_req) begin
      pc         <= EXC_VECTOR;
      fetch_adel <= |EXC_VECTOR[1:0];
      state      <= ST_RUN;
    end else if (eret_req) begin
      pc         <= epc;
      fetch_adel <= |epc[1:0];
      state      <= ST_RUN;
    end else begin
      case (state)
        // Redirects arriving here are wrong-path and are dropped.
        ST_PEND: begin
          if (!fetch_hold) begin
            pc         <= pend_tgt;
            fetch_adel <= |pend_tgt[1:0];
            state      <= ST_RUN;
          end
        end
        default: begin
          if (redir_valid && redir_legal) begin
            if (fetch_hold) begin
              pend_tgt <= redir_tgt;
              state    <= ST_PEND;
            end else begin
              pc         <= redir_tgt;
              fetch_adel <= |redir_tgt[1:0];
            end
          end else if (!fetch_hold) begin
            pc         <= seq_pc;
            fetch_adel <= |seq_pc[1:0];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-cycle model comparison plus
// directed literal checks.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_hold;
  logic        redir_valid;
  logic [1:0]  redir_op;
  logic [31:0] redir_base_pc;
  logic [15:0] b_imm;
  logic [25:0] j_imm;
  logic [31:0] rs;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic        pending;
  logic        fetch_adel;

  int n_cmp = 0;
  int n_bad = 0;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_hold    (fetch_hold),
    .redir_valid   (redir_valid),
    .redir_op      (redir_op),
    .redir_base_pc (redir_base_pc),
    .b_imm         (b_imm),
    .j_imm         (j_imm),
    .rs            (rs),
    .exc_req       (exc_req),
    .eret_req      (eret_req),
    .epc           (epc),
    .pc            (pc),
    .pending       (pending),
    .fetch_adel    (fetch_adel)
  );

  always #5 clk = ~clk;

  // Reference model: architectural PC, buffered-redirect flag and target.
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_tgt;
  bit          m_live = 1'b0;

  function automatic logic [31:0] model_target(input logic [1:0] op,
                                               input logic [31:0] base,
                                               input logic [15:0] bi,
                                               input logic [25:0] ji,
                                               input logic [31:0] r);
    logic [31:0] link;
    logic [31:0] off;
    link = base + 32'd4;
    off  = {{16{bi[15]}}, bi};
    if (op == 2'b01) return link + (off * 32'd4);
    if (op == 2'b10) return (link & 32'hF000_0000) | ({6'd0, ji} * 32'd4);
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc   <= 32'h0000_3000;
      m_pend <= 1'b0;
      m_tgt  <= 32'h0;
      m_live <= 1'b1;
    end else if (exc_req) begin
      m_pc   <= 32'h0000_4180;
      m_pend <= 1'b0;
    end else if (eret_req) begin
      m_pc   <= epc;
      m_pend <= 1'b0;
    end else if (m_pend) begin
      if (!fetch_hold) begin
        m_pc   <= m_tgt;
        m_pend <= 1'b0;
      end
    end else if (redir_valid && redir_op != 2'b00) begin
      if (fetch_hold) begin
        m_pend <= 1'b1;
        m_tgt  <= model_target(redir_op, redir_base_pc, b_imm, j_imm, rs);
      end else begin
        m_pc <= model_target(redir_op, redir_base_pc, b_imm, j_imm, rs);
      end
    end else if (!fetch_hold) begin
      m_pc <= m_pc + 32'd4;
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      n_cmp++;
      if (pc !== m_pc || pending !== m_pend || fetch_adel !== (m_pc[1:0] != 2'b00)) begin
        n_bad++;
        $display("FAIL model t=%0t: pc=%h pending=%b adel=%b, required pc=%h pending=%b adel=%b",
                 $time, pc, pending, fetch_adel, m_pc, m_pend, (m_pc[1:0] != 2'b00));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] exp_pc,
                     input logic exp_pend, input logic exp_adel);
    @(negedge clk);
    n_cmp++;
    if (pc !== exp_pc || pending !== exp_pend || fetch_adel !== exp_adel) begin
      n_bad++;
      $display("FAIL %s: pc=%h pending=%b adel=%b, required pc=%h pending=%b adel=%b",
               name, pc, pending, fetch_adel, exp_pc, exp_pend, exp_adel);
    end
  endtask

  task automatic redirect(input logic [1:0] op, input logic [31:0] base,
                          input logic [15:0] bi, input logic [25:0] ji,
                          input logic [31:0] r);
    redir_valid   = 1'b1;
    redir_op      = op;
    redir_base_pc = base;
    b_imm         = bi;
    j_imm         = ji;
    rs            = r;
  endtask

  initial begin
    reset = 1'b1; fetch_hold = 1'b0; redir_valid = 1'b0; redir_op = 2'b00;
    redir_base_pc = '0; b_imm = '0; j_imm = '0; rs = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset", 32'h3000, 1'b0, 1'b0);
    tick(); chk("seq1", 32'h3004, 1'b0, 1'b0);
    tick(); chk("seq2", 32'h3008, 1'b0, 1'b0);
    tick(); chk("seq3", 32'h300C, 1'b0, 1'b0);

    redirect(2'b01, 32'h3008, 16'hFFFE, 26'h0, 32'h0);
    tick(); redir_valid = 1'b0;
    chk("br_back", 32'h3004, 1'b0, 1'b0);

    redirect(2'b10, 32'h3FFF_FFFC, 16'h0, 26'h000_0400, 32'h0);
    tick(); redir_valid = 1'b0;
    chk("j_carry", 32'h4000_1000, 1'b0, 1'b0);

    redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h3102);
    fetch_hold = 1'b1;
    tick(); redir_valid = 1'b0;
    chk("jr_hold1", 32'h4000_1000, 1'b1, 1'b0);
    redirect(2'b10, 32'h0, 16'h0, 26'h5, 32'h0);
    tick(); redir_valid = 1'b0;
    chk("jr_hold2", 32'h4000_1000, 1'b1, 1'b0);
    tick(); chk("jr_hold3", 32'h4000_1000, 1'b1, 1'b0);
    fetch_hold = 1'b0;
    tick(); chk("jr_release", 32'h3102, 1'b0, 1'b1);
    tick(); chk("misaligned_seq", 32'h3106, 1'b0, 1'b1);

    redirect(2'b01, 32'h3000, 16'h0004, 26'h0, 32'h0);
    fetch_hold = 1'b1;
    tick(); redir_valid = 1'b0;
    chk("br_pend", 32'h3106, 1'b1, 1'b1);
    fetch_hold = 1'b0;
    redirect(2'b10, 32'h0, 16'h0, 26'h1, 32'h0);
    tick(); redir_valid = 1'b0;
    chk("release_drops_new", 32'h3014, 1'b0, 1'b0);

    redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h3200);
    fetch_hold = 1'b1;
    tick(); redir_valid = 1'b0;
    chk("pend_before_exc", 32'h3014, 1'b1, 1'b0);
    exc_req = 1'b1;
    tick(); exc_req = 1'b0;
    chk("exc_in_hold", 32'h4180, 1'b0, 1'b0);
    fetch_hold = 1'b0;
    tick(); chk("after_exc", 32'h4184, 1'b0, 1'b0);
    eret_req = 1'b1; epc = 32'h3020;
    tick(); eret_req = 1'b0;
    chk("eret", 32'h3020, 1'b0, 1'b0);

    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h7000;
    redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h5000);
    tick(); exc_req = 1'b0; eret_req = 1'b0; redir_valid = 1'b0;
    chk("exc_priority", 32'h4180, 1'b0, 1'b0);

    fetch_hold = 1'b1;
    tick(); chk("run_hold", 32'h4180, 1'b0, 1'b0);
    fetch_hold = 1'b0;
    redirect(2'b00, 32'h0, 16'h0, 26'h0, 32'h9000);
    tick(); redir_valid = 1'b0;
    chk("reserved_op", 32'h4184, 1'b0, 1'b0);

    redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h5000);
    fetch_hold = 1'b1;
    tick(); redir_valid = 1'b0;
    chk("pend_before_reset", 32'h4184, 1'b1, 1'b0);
    reset = 1'b1;
    tick(); reset = 1'b0; fetch_hold = 1'b0;
    chk("reset_in_pend", 32'h3000, 1'b0, 1'b0);
    tick(); chk("target_discarded", 32'h3004, 1'b0, 1'b0);

    redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
    tick(); redir_valid = 1'b0;
    chk("jr_top", 32'hFFFF_FFFC, 1'b0, 1'b0);
    tick(); chk("seq_wrap", 32'h0000_0000, 1'b0, 1'b0);

    tick();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
